// File: rtl/fproc_arbiter_pkg.sv
// Shared types and defaults for the fproc arbiter: FSM encodings, default widths,
// and the timeout counter sizing helper.
package fproc_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } fproc_state_t;

  localparam int DEF_ID_WIDTH   = 8;
  localparam int DEF_DATA_WIDTH = 32;

  // A disabled timeout (0 cycles) still needs a 1-bit counter that simply stays at 0.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/fproc_arbiter_rr_priority_sel.sv
// Combinational round-robin picker: first set bit of pending at or after rr_ptr,
// wrapping modulo N.
module rr_priority_sel
  import fproc_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_valid
);

  always_comb begin
    int idx;
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!any_valid && pending[idx]) begin
        any_valid = 1'b1;
        grant     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fproc_arbiter.sv
// Shares one fproc among N_CORES cores: latches per-core requests, grants round-robin,
// runs one fproc transaction at a time and routes the (or a forced zero) result back.
module fproc_arbiter
  import fproc_arbiter_pkg::*;
#(
  parameter int N_CORES        = 4,
  parameter int ID_WIDTH       = DEF_ID_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          core_req,
  input  logic [N_CORES*ID_WIDTH-1:0] core_id,
  output logic [N_CORES-1:0]          core_ready,
  output logic [DATA_WIDTH-1:0]       core_data,
  output logic                        fproc_enable,
  output logic [ID_WIDTH-1:0]         fproc_id,
  input  logic                        fproc_ready,
  input  logic [DATA_WIDTH-1:0]       fproc_data,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CORES - 1);

  fproc_state_t            state_q;
  logic [N_CORES-1:0]      pending_q;
  logic [ID_WIDTH-1:0]     ids_q [N_CORES];
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [IDX_W-1:0]        rr_ptr_d;
  logic [IDX_W-1:0]        winner_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [N_CORES-1:0]      core_ready_q;
  logic [DATA_WIDTH-1:0]   core_data_q;
  logic                    fproc_enable_q;
  logic [ID_WIDTH-1:0]     fproc_id_q;
  logic                    timeout_err_q;

  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_vld;

  rr_priority_sel #(
    .N     (N_CORES),
    .IDX_W (IDX_W)
  ) u_sel (
    .pending   (pending_q),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant_idx),
    .any_valid (grant_vld)
  );

  assign rr_ptr_d = (winner_q == IDX_LAST) ? '0 : winner_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      for (int i = 0; i < N_CORES; i++) ids_q[i] <= '0;
      rr_ptr_q       <= '0;
      winner_q       <= '0;
      cnt_q          <= '0;
      core_ready_q   <= '0;
      core_data_q    <= '0;
      fproc_enable_q <= 1'b0;
      fproc_id_q     <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      fproc_enable_q <= 1'b0;
      core_ready_q   <= '0;

      // A repeat pulse from a core already waiting keeps its original id.
      for (int i = 0; i < N_CORES; i++) begin
        if (core_req[i] && !pending_q[i]) begin
          pending_q[i] <= 1'b1;
          ids_q[i]     <= core_id[i*ID_WIDTH +: ID_WIDTH];
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            winner_q       <= grant_idx;
            fproc_enable_q <= 1'b1;
            fproc_id_q     <= ids_q[grant_idx];
            state_q        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fproc_ready) begin
            core_data_q  <= fproc_data;
            core_ready_q <= N_CORES'(1) << winner_q;
            state_q      <= ST_RESPOND;
          end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
            core_data_q   <= '0;
            timeout_err_q <= 1'b1;
            core_ready_q  <= N_CORES'(1) << winner_q;
            state_q       <= ST_RESPOND;
          end else if (TIMEOUT_EN) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESPOND: begin
          pending_q[winner_q] <= 1'b0;
          rr_ptr_q            <= rr_ptr_d;
          state_q             <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_ready   = core_ready_q;
  assign core_data    = core_data_q;
  assign fproc_enable = fproc_enable_q;
  assign fproc_id     = fproc_id_q;
  assign timeout_err  = timeout_err_q;
  assign busy         = (state_q != ST_IDLE) || (|pending_q);

endmodule
